// File: rtl/prefetch_width_fifo.sv
// First-word-fall-through FIFO that accepts wide words and emits them as narrow
// slices, with flush, fill level, almost-full and selectable slice order.
module prefetch_width_fifo #(
   parameter int WR_DATA_WIDTH = 128,
   parameter int RATIO         = 8,
   parameter int DEPTH_WIDTH   = 5,
   parameter int AF_LEVEL      = 28,
   parameter int LSB_FIRST     = 1,
   localparam int RD_DATA_WIDTH = WR_DATA_WIDTH / RATIO
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   input  logic                     wr_en,
   input  logic [WR_DATA_WIDTH-1:0] wr_data,
   output logic                     wr_vld,
   input  logic                     rd_en,
   output logic                     rd_vld,
   output logic [RD_DATA_WIDTH-1:0] rd_data,
   output logic [DEPTH_WIDTH:0]     wr_level,
   output logic                     almost_full
);

   localparam int SEL_W = (RATIO > 1) ? $clog2(RATIO) : 1;
   localparam int DEPTH = 1 << DEPTH_WIDTH;
   localparam logic [DEPTH_WIDTH:0] FULL_LEVEL = (DEPTH_WIDTH + 1)'(DEPTH);
   localparam logic [DEPTH_WIDTH:0] AF_THRESH  = (DEPTH_WIDTH + 1)'(AF_LEVEL);

   logic [WR_DATA_WIDTH-1:0] mem [DEPTH];
   logic [DEPTH_WIDTH:0]     wr_ptr;
   logic [DEPTH_WIDTH:0]     rd_ptr;
   logic [WR_DATA_WIDTH-1:0] cur;
   logic [SEL_W-1:0]         sel;

   logic mem_empty;
   logic last_slice;
   logic wr_fire;
   logic consume;
   logic pop;

   // Handshakes: a word transfers on a clock where wr_en && wr_vld; a slice is
   // consumed on a clock where rd_en && rd_vld. wr_vld and rd_vld never depend
   // on wr_en or rd_en in the same cycle.
   assign wr_level    = wr_ptr - rd_ptr;
   assign mem_empty   = (wr_ptr == rd_ptr);
   assign wr_vld      = (wr_level != FULL_LEVEL);
   assign almost_full = (wr_level >= AF_THRESH);
   assign last_slice  = (RATIO == 1) ? 1'b1 : (sel == SEL_W'(RATIO - 1));
   assign wr_fire     = wr_en && wr_vld && !flush;
   assign consume     = rd_en && rd_vld;

   // Refill cur either when idle (prefetch) or as the last slice leaves, so a
   // word boundary costs no bubble.
   assign pop = !mem_empty && !flush && (!rd_vld || (consume && last_slice));

   // Storage is plain LUT RAM: no reset, combinational read.
   always_ff @(posedge clk) begin
      if (wr_fire) begin
         mem[wr_ptr[DEPTH_WIDTH-1:0]] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cur    <= '0;
         sel    <= '0;
         rd_vld <= 1'b0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         sel    <= '0;
         rd_vld <= 1'b0;
      end else begin
         if (wr_fire) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            cur    <= mem[rd_ptr[DEPTH_WIDTH-1:0]];
            rd_ptr <= rd_ptr + 1'b1;
            sel    <= '0;
            rd_vld <= 1'b1;
         end else if (consume) begin
            if (last_slice) begin
               sel    <= '0;
               rd_vld <= 1'b0;
            end else begin
               sel <= sel + 1'b1;
            end
         end
      end
   end

   generate
      if (RATIO == 1) begin : g_no_slice
         assign rd_data = cur;
      end else begin : g_slice
         logic [RD_DATA_WIDTH-1:0] slices [RATIO];
         logic [SEL_W-1:0]         idx;
         for (genvar i = 0; i < RATIO; i++) begin : g_cut
            assign slices[i] = cur[i*RD_DATA_WIDTH +: RD_DATA_WIDTH];
         end
         // RATIO is a power of two, so RATIO-1-sel is simply ~sel.
         assign idx     = (LSB_FIRST != 0) ? sel : ~sel;
         assign rd_data = slices[idx];
      end
   endgenerate

endmodule

// File: tb/tb_prefetch_width_fifo.sv
// Self-checking bench for prefetch_width_fifo: vector table, directed corner
// sequences and random traffic against a word/slice queue model.
module tb_prefetch_width_fifo;

   localparam int WW = 128;
   localparam int RW = 16;
   localparam int R  = 8;
   localparam int DW = 5;
   localparam int CAP = 32;
   localparam int AF = 28;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          flush = 1'b0;
   logic          wr_en = 1'b0;
   logic [WW-1:0] wr_data = '0;
   logic          rd_en = 1'b0;
   logic          wr_vld, rd_vld, almost_full;
   logic [RW-1:0] rd_data;
   logic [DW:0]   wr_level;
   logic          wr_vld_m, rd_vld_m, almost_full_m;
   logic [RW-1:0] rd_data_m;
   logic [DW:0]   wr_level_m;

   int n_cmp = 0;
   int n_err = 0;

   // reference state: stored words plus remaining slices of the output word
   logic [WW-1:0] mem_q[$];
   logic [RW-1:0] exp_q[$];
   logic [RW-1:0] exp_msb_q[$];

   typedef struct {
      logic          wr_en;
      logic [WW-1:0] wr_data;
      logic          rd_en;
      logic          flush;
      logic          exp_vld;
      logic [RW-1:0] exp_lsb;
      logic [RW-1:0] exp_msb;
      logic [DW:0]   exp_level;
   } vec_t;
   vec_t tbl[10];

   prefetch_width_fifo #(.WR_DATA_WIDTH(WW), .RATIO(R), .DEPTH_WIDTH(DW),
                         .AF_LEVEL(AF), .LSB_FIRST(1)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
      .wr_vld(wr_vld), .rd_en(rd_en), .rd_vld(rd_vld), .rd_data(rd_data),
      .wr_level(wr_level), .almost_full(almost_full));

   prefetch_width_fifo #(.WR_DATA_WIDTH(WW), .RATIO(R), .DEPTH_WIDTH(DW),
                         .AF_LEVEL(AF), .LSB_FIRST(0)) dut_msb (
      .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
      .wr_vld(wr_vld_m), .rd_en(rd_en), .rd_vld(rd_vld_m), .rd_data(rd_data_m),
      .wr_level(wr_level_m), .almost_full(almost_full_m));

   // clock / reset
   always #5 clk = ~clk;

   function automatic logic [WW-1:0] mk_word(input int base);
      logic [WW-1:0] w;
      for (int i = 0; i < R; i++) w[i*RW +: RW] = RW'(base + i);
      return w;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      mem_q.delete();
      exp_q.delete();
      exp_msb_q.delete();
   endtask

   // one clock of the spec rules, using pre-edge inputs and contents
   task automatic model_step();
      logic [WW-1:0] w;
      bit            accept;
      if (!rst_n || flush) begin
         model_clear();
         return;
      end
      accept = wr_en && (mem_q.size() < CAP);
      if (rd_en && exp_q.size() > 0) begin
         void'(exp_q.pop_front());
         void'(exp_msb_q.pop_front());
      end
      if (exp_q.size() == 0 && mem_q.size() > 0) begin
         w = mem_q.pop_front();
         for (int i = 0; i < R; i++) begin
            exp_q.push_back(w[i*RW +: RW]);
            exp_msb_q.push_back(w[(R-1-i)*RW +: RW]);
         end
      end
      if (accept) mem_q.push_back(wr_data);
   endtask

   task automatic check_model();
      bit vld;
      vld = (exp_q.size() != 0);
      check("m_rd_vld", 32'(rd_vld), 32'(vld));
      check("m_rd_vld_msb", 32'(rd_vld_m), 32'(vld));
      if (vld) begin
         check("m_rd_data", 32'(rd_data), 32'(exp_q[0]));
         check("m_rd_data_msb", 32'(rd_data_m), 32'(exp_msb_q[0]));
      end
      check("m_wr_level", 32'(wr_level), 32'(mem_q.size()));
      check("m_wr_vld", 32'(wr_vld), 32'(mem_q.size() != CAP));
      check("m_almost_full", 32'(almost_full), 32'(mem_q.size() >= AF));
   endtask

   // driver: inputs are set at the falling edge before calling this
   task automatic cycle();
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_model();
   endtask

   task automatic drive(input logic w, input logic [WW-1:0] d, input logic r, input logic f);
      wr_en = w; wr_data = d; rd_en = r; flush = f;
   endtask

   task automatic do_flush();
      drive(1'b0, '0, 1'b0, 1'b1);
      cycle();
      drive(1'b0, '0, 1'b0, 1'b0);
   endtask

   task automatic fill_table();
      tbl[0] = '{1'b1, mk_word(0), 1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 6'd1};
      tbl[1] = '{1'b0, '0, 1'b1, 1'b0, 1'b1, 16'h0, 16'h7, 6'd0};
      for (int i = 2; i <= 8; i++)
         tbl[i] = '{1'b0, '0, 1'b1, 1'b0, 1'b1, RW'(i - 1), RW'(8 - i), 6'd0};
      tbl[9] = '{1'b0, '0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 6'd0};
   endtask

   task automatic run_table(input string tag);
      for (int i = 0; i < 10; i++) begin
         drive(tbl[i].wr_en, tbl[i].wr_data, tbl[i].rd_en, tbl[i].flush);
         cycle();
         check({tag, "_vld"}, 32'(rd_vld), 32'(tbl[i].exp_vld));
         check({tag, "_vld_msb"}, 32'(rd_vld_m), 32'(tbl[i].exp_vld));
         check({tag, "_level"}, 32'(wr_level), 32'(tbl[i].exp_level));
         if (tbl[i].exp_vld) begin
            check({tag, "_lsb"}, 32'(rd_data), 32'(tbl[i].exp_lsb));
            check({tag, "_msb"}, 32'(rd_data_m), 32'(tbl[i].exp_msb));
         end
      end
      drive(1'b0, '0, 1'b0, 1'b0);
   endtask

   initial begin
      logic [RW-1:0] got[$];
      int budget;

      // reset values
      drive(1'b0, '0, 1'b0, 1'b0);
      repeat (2) cycle();
      check("rst_rd_vld", 32'(rd_vld), 32'd0);
      check("rst_rd_data", 32'(rd_data), 32'd0);
      check("rst_wr_level", 32'(wr_level), 32'd0);
      check("rst_almost_full", 32'(almost_full), 32'd0);
      check("rst_wr_vld", 32'(wr_vld), 32'd1);
      rst_n = 1'b1;
      cycle();

      // single word, both slice orders
      fill_table();
      run_table("s1");

      // fill past capacity, then drain
      do_flush();
      for (int k = 1; k <= 34; k++) begin
         drive(1'b1, mk_word(k * 16), 1'b0, 1'b0);
         cycle();
         if (k == 28) check("fill_af_low", 32'(almost_full), 32'd0);
         if (k == 29) check("fill_af_at28", 32'(almost_full), 32'd1);
         if (k == 32) check("fill_wr_vld_31", 32'(wr_vld), 32'd1);
         if (k == 33) check("fill_wr_vld_full", 32'(wr_vld), 32'd0);
         if (k == 34) check("fill_level_drop", 32'(wr_level), 32'd32);
      end
      check("fill_cur_word1", 32'(rd_data), 32'h10);
      got.delete();
      if (rd_vld) got.push_back(rd_data);
      drive(1'b0, '0, 1'b1, 1'b0);
      budget = 400;
      while (rd_vld && budget > 0) begin
         cycle();
         if (rd_vld) got.push_back(rd_data);
         budget--;
      end
      check("drain_timeout", 32'(budget > 0), 32'd1);
      check("drain_count", 32'(got.size()), 32'(33 * R));
      for (int j = 0; j < got.size() && j < 33 * R; j++)
         check("drain_data", 32'(got[j]), 32'((j / R + 1) * 16 + j % R));
      drive(1'b0, '0, 1'b0, 1'b0);

      // streaming without bubbles
      do_flush();
      for (int c = 0; c <= 82; c++) begin
         drive((c % 8 == 0) && (c < 80), mk_word((c / 8) * 8), 1'b1, 1'b0);
         cycle();
         if (c >= 1 && c <= 80) begin
            check("stream_vld", 32'(rd_vld), 32'd1);
            check("stream_data", 32'(rd_data), 32'(c - 1));
         end
         check("stream_level_le1", 32'(wr_level <= 1), 32'd1);
      end
      drive(1'b0, '0, 1'b0, 1'b0);

      // write and last-slice pop together
      do_flush();
      for (int k = 1; k <= 6; k++) begin
         drive(1'b1, mk_word(k * 16), 1'b0, 1'b0);
         cycle();
      end
      for (int s = 0; s < 7; s++) begin
         drive(1'b0, '0, 1'b1, 1'b0);
         cycle();
      end
      check("sim_pre_level", 32'(wr_level), 32'd5);
      check("sim_pre_last", 32'(rd_data), 32'h17);
      drive(1'b1, mk_word(7 * 16), 1'b1, 1'b0);
      cycle();
      check("sim_level", 32'(wr_level), 32'd5);
      check("sim_next_slice", 32'(rd_data), 32'h20);
      check("sim_vld", 32'(rd_vld), 32'd1);

      // flush mid-word with a concurrent write
      do_flush();
      for (int k = 1; k <= 11; k++) begin
         drive(1'b1, mk_word(k * 16), 1'b0, 1'b0);
         cycle();
      end
      for (int s = 0; s < 3; s++) begin
         drive(1'b0, '0, 1'b1, 1'b0);
         cycle();
      end
      check("fl_pre_level", 32'(wr_level), 32'd10);
      check("fl_pre_sel3", 32'(rd_data), 32'h13);
      drive(1'b1, mk_word(16'h990), 1'b1, 1'b1);
      cycle();
      check("fl_vld", 32'(rd_vld), 32'd0);
      check("fl_level", 32'(wr_level), 32'd0);
      drive(1'b1, mk_word(16'h500), 1'b0, 1'b0);
      cycle();
      drive(1'b0, '0, 1'b0, 1'b0);
      cycle();
      check("fl_new_vld", 32'(rd_vld), 32'd1);
      check("fl_new_slice0", 32'(rd_data), 32'h500);
      check("fl_new_level", 32'(wr_level), 32'd0);

      // random traffic: write-heavy, balanced, read-heavy phases
      do_flush();
      for (int p = 0; p < 3; p++) begin
         for (int c = 0; c < 300; c++) begin
            drive($urandom_range(0, 99) < (p == 0 ? 90 : (p == 1 ? 55 : 25)),
                  {$urandom, $urandom, $urandom, $urandom},
                  $urandom_range(0, 99) < (p == 0 ? 30 : (p == 1 ? 60 : 90)),
                  $urandom_range(0, 199) == 0);
            cycle();
         end
      end
      drive(1'b0, '0, 1'b0, 1'b0);

      // asynchronous reset during streaming
      do_flush();
      for (int c = 0; c < 14; c++) begin
         drive(c < 12, mk_word(c * 8), 1'b1, 1'b0);
         cycle();
      end
      check("ar_pre_level_nz", 32'(wr_level != 0), 32'd1);
      @(posedge clk);
      model_step();
      #2;
      rst_n = 1'b0;
      model_clear();
      #1;
      check("ar_rd_vld", 32'(rd_vld), 32'd0);
      check("ar_wr_level", 32'(wr_level), 32'd0);
      check("ar_rd_data", 32'(rd_data), 32'd0);
      @(negedge clk);
      drive(1'b0, '0, 1'b0, 1'b0);
      cycle();
      rst_n = 1'b1;
      cycle();
      run_table("s6");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/prefetch_width_fifo.md
# prefetch_width_fifo

Single-clock, first-word-fall-through FIFO with a parametrised write-to-read width ratio. Wide words, typically DDR burst beats from the frame-buffer read path, are accepted on the write side. They are presented on the read side as narrow slices, typically pixels for the video output stage. It extends the fixed 128-to-16 read-FIFO generation with:
- a run-time flush
- a fill level and an almost-full flag
- selectable slice order
- no-bubble streaming across word boundaries

## Interface
Parameters:
- WR_DATA_WIDTH, 128, write word width; must equal RATIO × RD_DATA_WIDTH
- RATIO, 8, slices per word; power of 2, 1..16
- RD_DATA_WIDTH, WR_DATA_WIDTH/RATIO, derived; not overridable
- DEPTH_WIDTH, 5, memory holds 2^DEPTH_WIDTH words; range 2..6, LUT RAM with combinational read
- AF_LEVEL, 28, almost_full threshold in words; range 1..2^DEPTH_WIDTH
- LSB_FIRST, 1, 1 = slice 0 is wr_data[RD_DATA_WIDTH-1:0]; 0 = MSB slice first

Ports:
- clk  in  1  single clock for all logic
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous clear of all contents
- wr_en  in  1  write request
- wr_data  in  WR_DATA_WIDTH  write word
- wr_vld  out  1  space available; a write is accepted only when wr_en && wr_vld
- rd_en  in  1  slice consume; effective only when rd_vld
- rd_vld  out  1  rd_data holds a valid slice
- rd_data  out  RD_DATA_WIDTH  current slice
- wr_level  out  DEPTH_WIDTH+1  words held in memory (excludes output register)
- almost_full  out  1  wr_level >= AF_LEVEL

## Operation
Storage:
- Memory of 2^DEPTH_WIDTH words. Write and read pointers are DEPTH_WIDTH+1 bits, so full and empty are distinguished by the MSB; pointers wrap modulo 2^(DEPTH_WIDTH+1).
- One output word register (cur) plus a slice counter sel of log2(RATIO) bits. Total capacity is 2^DEPTH_WIDTH + 1 words.

Output selection:
- rd_data = slice sel of cur when LSB_FIRST = 1, otherwise slice RATIO-1-sel.
- When RATIO = 1, sel is absent and rd_data = cur.

Consume (rd_en && rd_vld):
- If sel ≠ RATIO-1: sel increments.
- If sel = RATIO-1 and memory is non-empty: cur loads mem[rd_ptr], rd_ptr increments, sel returns to 0. rd_vld stays 1.
- If sel = RATIO-1 and memory is empty: rd_vld clears and sel returns to 0.

Prefetch:
- When rd_vld = 0 and memory is non-empty, cur loads mem[rd_ptr], rd_ptr increments, rd_vld sets and sel is 0.

Level and flags:
- wr_level = wr_ptr − rd_ptr.
- wr_vld = (wr_level ≠ 2^DEPTH_WIDTH), combinational.
- almost_full = (wr_level >= AF_LEVEL), combinational.

Boundary conditions:
- wr_en while full: the write is dropped, wr_ptr does not change, no error flag.
- Write and memory pop in the same cycle: wr_level is unchanged.
- A write while full and a pop in the same cycle: the write is still dropped, because wr_vld is decoded from the pre-edge level.
- flush = 1: next edge clears both pointers, sel and rd_vld. wr_en and rd_en in that cycle are ignored. Memory contents need not be cleared.
- rst_n low: all state clears immediately, regardless of clk.

## Timing
Reset values:
- rd_vld 0, rd_data 0, wr_level 0, almost_full 0, wr_vld 1.
- cur is reset to 0.

Latency and throughput:
- Write-to-read latency: a word written at edge k into an empty FIFO gives rd_vld = 1 after edge k+1 (one clock).
- Sustained rate: one slice per clock with no bubble at word boundaries while memory is non-empty.
- Write side accepts one word per clock.
- wr_level updates on the edge after the write or pop.

Reset and flush timing:
- rst_n assertion is asynchronous.
- rst_n deassertion is taken synchronously by the first clk edge after release; the integrator supplies a release-synchronised rst_n.
- Flush takes effect in one clock.

## Test plan
Defaults for all scenarios: WR_DATA_WIDTH = 128, RATIO = 8, DEPTH_WIDTH = 5.

1. **Single word.** After reset, write one word with 16-bit slices 0x0007…0x0000 (LSB slice = 0x0000), then hold rd_en = 1.
   - rd_vld rises one clock after the write.
   - rd_data steps 0x0000, 0x0001, … 0x0007 on consecutive clocks, then rd_vld = 0.
   - Rerun with LSB_FIRST = 0: order is 0x0007 … 0x0000.
2. **Fill.** Issue 34 back-to-back writes with no reads.
   - Word 1 moves to cur.
   - almost_full asserts when wr_level = 28.
   - wr_vld = 0 when wr_level = 32; the 34th write is dropped.
   - Draining returns words 1..33 exactly, with the 34th absent.
3. **Streaming.** Write an incrementing word every 8 clocks with rd_en held at 1.
   - rd_data increments by 1 every clock for 10 words, with no rd_vld gap.
   - wr_level never exceeds 1.
4. **Simultaneous events.** At wr_level = 5, a write and a last-slice consume occur in the same cycle.
   - wr_level stays 5.
   - The next slice is slice 0 of the oldest stored word.
5. **Flush mid-word.** Assert flush at sel = 3 with wr_level = 10 and wr_en = 1.
   - Next clock: rd_vld = 0, wr_level = 0, and the concurrent write is not stored.
   - A following write returns slice 0 of the new word.
6. **Async reset mid-operation.** Pull rst_n low between clock edges during streaming.
   - rd_vld and wr_level go to 0 before the next edge.
   - After release, the scenario 1 sequence passes.
